// File: rtl/seidel_mac_pipe.sv
// seidel_mac_pipe: pipelined multiplier with a ce-gated accumulator.
// It also keeps a sticky overflow flag for the accumulator.
module seidel_mac_pipe #(
    parameter int A_WIDTH   = 10,
    parameter int B_WIDTH   = 11,
    parameter int P_WIDTH   = 20,
    parameter int NUM_STAGE = 3,
    parameter int SIGNED    = 0,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    output logic                 out_valid,
    output logic [P_WIDTH-1:0]   dout,
    output logic                 acc_valid,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_ovf
);
    localparam int PD = NUM_STAGE - 1;

    logic [A_WIDTH-1:0]   a_q, a_d;
    logic [B_WIDTH-1:0]   b_q, b_d;
    logic [P_WIDTH-1:0]   prod_q [PD];
    logic [P_WIDTH-1:0]   prod_d [PD];
    logic [NUM_STAGE-1:0] vld_q, vld_d, en_q, en_d, clr_q, clr_d;
    logic [P_WIDTH-1:0]   dout_q, dout_d;
    logic                 ov_q, ov_d, oen_q, oen_d, oclr_q, oclr_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 accv_q, accv_d, ovf_q, ovf_d;
    logic [P_WIDTH-1:0]   a_ext, b_ext;
    logic [ACC_WIDTH-1:0] p_ext;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf_now;

    always_comb begin
        a_d   = din0;
        b_d   = din1;
        vld_d = {vld_q[NUM_STAGE-2:0], in_valid};
        en_d  = {en_q[NUM_STAGE-2:0], in_valid & acc_en};
        clr_d = {clr_q[NUM_STAGE-2:0], in_valid & acc_clr};
        // Extending to P_WIDTH before multiplying keeps the low product bits exact for both signednesses
        a_ext = (SIGNED != 0) ? P_WIDTH'($signed(a_q)) : P_WIDTH'(a_q);
        b_ext = (SIGNED != 0) ? P_WIDTH'($signed(b_q)) : P_WIDTH'(b_q);
        prod_d[0] = a_ext * b_ext;
        for (int i = 1; i < PD; i++) prod_d[i] = prod_q[i-1];
        ov_d   = vld_q[NUM_STAGE-1];
        oen_d  = en_q[NUM_STAGE-1];
        oclr_d = clr_q[NUM_STAGE-1];
        dout_d = vld_q[NUM_STAGE-1] ? prod_q[PD-1] : dout_q;
        p_ext  = (SIGNED != 0) ? ACC_WIDTH'($signed(dout_q)) : ACC_WIDTH'(dout_q);
        sum    = {1'b0, acc_q} + {1'b0, p_ext};
        ovf_now = (SIGNED != 0) ? (acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1])
                                : sum[ACC_WIDTH];
        accv_d = ov_q & (oen_q | oclr_q);
        acc_d  = !ov_q ? acc_q : oclr_q ? (oen_q ? p_ext : '0) : oen_q ? sum[ACC_WIDTH-1:0] : acc_q;
        ovf_d  = !ov_q ? ovf_q : oclr_q ? 1'b0 : (ovf_q | (oen_q & ovf_now));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            for (int i = 0; i < PD; i++) prod_q[i] <= '0;
            vld_q  <= '0;
            en_q   <= '0;
            clr_q  <= '0;
            dout_q <= '0;
            ov_q   <= 1'b0;
            oen_q  <= 1'b0;
            oclr_q <= 1'b0;
            acc_q  <= '0;
            accv_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (ce) begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            vld_q  <= vld_d;
            en_q   <= en_d;
            clr_q  <= clr_d;
            dout_q <= dout_d;
            ov_q   <= ov_d;
            oen_q  <= oen_d;
            oclr_q <= oclr_d;
            acc_q  <= acc_d;
            accv_q <= accv_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = ov_q;
    assign dout      = dout_q;
    assign acc_valid = accv_q;
    assign acc_out   = acc_q;
    assign acc_ovf   = ovf_q;
endmodule

// File: tb/tb_seidel_mac_pipe.sv
// tb_seidel_mac_pipe: unsigned, signed and 21-bit-accumulator instances driven with shared stimulus.
// It compares their outputs against a queue of expected results.
module tb_seidel_mac_pipe;
    localparam int NS = 3;

    logic        clk = 0, reset_n = 1, ce = 0, in_valid = 0, acc_en = 0, acc_clr = 0;
    logic [9:0]  din0 = 0;
    logic [10:0] din1 = 0;
    logic        ov0, ov1, ov2, av0, av1, av2, of0, of1, of2;
    logic [19:0] d0, d1, d2;
    logic [31:0] a0, a1;
    logic [20:0] a2;

    seidel_mac_pipe u0 (.clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov0), .dout(d0), .acc_valid(av0), .acc_out(a0), .acc_ovf(of0));
    seidel_mac_pipe #(.SIGNED(1)) u1 (.clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov1), .dout(d1), .acc_valid(av1), .acc_out(a1), .acc_ovf(of1));
    seidel_mac_pipe #(.ACC_WIDTH(21)) u2 (.clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov2), .dout(d2), .acc_valid(av2), .acc_out(a2), .acc_ovf(of2));

    always #5 clk = ~clk;

    typedef struct { logic [9:0] a; logic [10:0] b; bit en; bit clr; logic [19:0] eu; logic [19:0] es; logic [20:0] ea2; bit eo2; } vec_t;
    typedef struct { logic [19:0] u; logic [19:0] s; int e; } pexp_t;
    typedef struct { logic [31:0] au; logic [31:0] as; bit ou; bit os; logic [20:0] a2; bit o2; int e; } aexp_t;

    pexp_t pq[$];
    aexp_t aq[$];
    int n_chk = 0, n_fail = 0, edge_cnt = 0;
    bit ce_s = 0;
    longint macc[3];
    bit movf[3];
    logic [19:0] cu = 0, cs = 0;
    logic [31:0] cau = 0, cas = 0;
    logic [20:0] ca2 = 0;
    bit cou = 0, cos = 0, co2 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        return v[w-1] ? v - (longint'(1) << w) : v;
    endfunction

    function automatic longint prod(input longint a, input longint b, input bit sg);
        longint x = sg ? sx(a, 10) : a;
        longint y = sg ? sx(b, 11) : b;
        return (x * y) & ((longint'(1) << 20) - 1);
    endfunction

    task automatic acc_step(input int i, input longint p, input bit sg, input int w, input bit en, input bit clr);
        longint lim = longint'(1) << w;
        longint e = sg ? sx(p, 20) : p;
        longint s;
        if (clr) begin
            macc[i] = en ? (e & (lim - 1)) : 0;
            movf[i] = 0;
        end else if (en) begin
            s = sg ? sx(macc[i], w) + e : macc[i] + e;
            if (sg ? (s >= lim / 2 || s < -(lim / 2)) : (s >= lim)) movf[i] = 1;
            macc[i] = s & (lim - 1);
        end
    endtask

    task automatic drive(input logic [9:0] a, input logic [10:0] b, input bit v, input bit en, input bit clr, input bit c,
                         input bit tab, input logic [19:0] eu, input logic [19:0] es, input logic [20:0] ea2, input bit eo2);
        logic [19:0] pu, ps;
        @(negedge clk);
        din0 = a; din1 = b; in_valid = v; acc_en = en; acc_clr = clr; ce = c;
        if (c && v && reset_n) begin
            pu = tab ? eu : 20'(prod(longint'(a), longint'(b), 0));
            ps = tab ? es : 20'(prod(longint'(a), longint'(b), 1));
            pq.push_back('{pu, ps, edge_cnt + 1});
            acc_step(0, longint'(pu), 0, 32, en, clr);
            acc_step(1, longint'(ps), 1, 32, en, clr);
            acc_step(2, longint'(pu), 0, 21, en, clr);
            if (en || clr)
                aq.push_back('{32'(macc[0]), 32'(macc[1]), movf[0], movf[1],
                               tab ? ea2 : 21'(macc[2]), tab ? eo2 : movf[2], edge_cnt + 1});
        end
    endtask

    task automatic idle(input int n, input bit c);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, c, 0, 0, 0, 0, 0);
    endtask

    task automatic rst_checks();
        check("rst_flags", {55'd0, ov0, ov1, ov2, av0, av1, av2, of0, of1, of2}, 0);
        check("rst_dout", {4'd0, d0, d1, d2}, 0);
        check("rst_acc_u", {32'd0, a0}, 0);
        check("rst_acc_s_a21", {11'd0, a1, a2}, 0);
    endtask

    always @(posedge clk) begin
        ce_s = ce && reset_n;
        if (ce_s) edge_cnt++;
    end

    always @(negedge clk) begin
        bit ep, ea;
        if (ce_s && reset_n) begin
            while (pq.size() > 0 && pq[0].e + NS < edge_cnt) begin
                n_chk++; n_fail++;
                $display("FAIL product_missed: accepted edge %0d never seen, now edge %0d", pq[0].e, edge_cnt);
                void'(pq.pop_front());
            end
            while (aq.size() > 0 && aq[0].e + NS + 1 < edge_cnt) begin
                n_chk++; n_fail++;
                $display("FAIL acc_missed: accepted edge %0d never seen, now edge %0d", aq[0].e, edge_cnt);
                void'(aq.pop_front());
            end
            ep = pq.size() > 0 && pq[0].e + NS == edge_cnt;
            ea = aq.size() > 0 && aq[0].e + NS + 1 == edge_cnt;
            if (ep) begin
                cu = pq[0].u; cs = pq[0].s;
                void'(pq.pop_front());
            end
            if (ea) begin
                cau = aq[0].au; cas = aq[0].as; cou = aq[0].ou; cos = aq[0].os; ca2 = aq[0].a2; co2 = aq[0].o2;
                void'(aq.pop_front());
            end
            check("out_valid", {61'd0, ov0, ov1, ov2}, {61'd0, ep, ep, ep});
            check("dout_u", {44'd0, d0}, {44'd0, cu});
            check("dout_s", {44'd0, d1}, {44'd0, cs});
            check("dout_a21", {44'd0, d2}, {44'd0, cu});
            check("acc_valid", {61'd0, av0, av1, av2}, {61'd0, ea, ea, ea});
            check("acc_u", {32'd0, a0}, {32'd0, cau});
            check("acc_s", {32'd0, a1}, {32'd0, cas});
            check("acc_a21", {43'd0, a2}, {43'd0, ca2});
            check("acc_ovf", {61'd0, of0, of1, of2}, {61'd0, cou, cos, co2});
        end
    end

    initial begin
        vec_t tv[11];
        tv[0]  = '{10'd1023, 11'd2047, 1'b1, 1'b1, 20'hFF401, 20'h00001, 21'h0FF401, 1'b0};
        tv[1]  = '{10'd1023, 11'd2047, 1'b1, 1'b0, 20'hFF401, 20'h00001, 21'h1FE802, 1'b0};
        tv[2]  = '{10'd1023, 11'd2047, 1'b1, 1'b0, 20'hFF401, 20'h00001, 21'h0FDC03, 1'b1};
        tv[3]  = '{10'h3FF,  11'd5,    1'b1, 1'b1, 20'h013FB, 20'hFFFFB, 21'h0013FB, 1'b0};
        tv[4]  = '{10'd2,    11'd3,    1'b1, 1'b1, 20'd6,     20'd6,     21'd6,      1'b0};
        tv[5]  = '{10'd4,    11'd5,    1'b1, 1'b0, 20'd20,    20'd20,    21'd26,     1'b0};
        tv[6]  = '{10'd6,    11'd7,    1'b1, 1'b0, 20'd42,    20'd42,    21'd68,     1'b0};
        tv[7]  = '{10'd512,  11'd1024, 1'b0, 1'b0, 20'h80000, 20'h80000, 21'd0,      1'b0};
        tv[8]  = '{10'd0,    11'd2047, 1'b0, 1'b1, 20'd0,     20'd0,     21'd0,      1'b0};
        tv[9]  = '{10'd511,  11'd1023, 1'b1, 1'b1, 20'h7FA01, 20'h7FA01, 21'h07FA01, 1'b0};
        tv[10] = '{10'd1,    11'd1024, 1'b1, 1'b0, 20'h00400, 20'hFFC00, 21'h07FE01, 1'b0};
        for (int i = 0; i < 3; i++) begin macc[i] = 0; movf[i] = 0; end
        #1 reset_n = 0;
        #1 rst_checks();
        repeat (2) @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 11; i++)
            drive(tv[i].a, tv[i].b, 1, tv[i].en, tv[i].clr, 1, 1, tv[i].eu, tv[i].es, tv[i].ea2, tv[i].eo2);
        idle(6, 1);
        // two samples, then a two-cycle freeze while both are in flight
        drive(10'd2, 11'd3, 1, 1, 1, 1, 1, 20'd6, 20'd6, 21'd6, 0);
        drive(10'd4, 11'd5, 1, 1, 0, 1, 1, 20'd20, 20'd20, 21'd26, 0);
        idle(2, 0);
        idle(6, 1);
        for (int i = 0; i < 300; i++)
            drive(10'($urandom), 11'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, 0, 0, 0, 0, 0);
        idle(6, 1);
        drive(10'd100, 11'd200, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        drive(10'd300, 11'd400, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        drive(10'd0, 11'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        #2 reset_n = 0;
        #1 rst_checks();
        pq.delete();
        aq.delete();
        for (int i = 0; i < 3; i++) begin macc[i] = 0; movf[i] = 0; end
        cu = 0; cs = 0; cau = 0; cas = 0; ca2 = 0; cou = 0; cos = 0; co2 = 0;
        @(negedge clk);
        reset_n = 1;
        idle(10, 1);
        check("pq_drained", 64'(pq.size()), 0);
        check("aq_drained", 64'(aq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
